// File: rtl/hls_deadlock_chan_monitor.sv
// Per-process deadlock monitor: declares a deadlock when a selected AXI-stream
// channel stays blocked for PERSIST consecutive non-idle cycles.
module hls_deadlock_chan_monitor #(
  parameter int                N_AXIS   = 7,
  parameter logic [N_AXIS-1:0] SEL_MASK = 7'b0111000,
  parameter int                PERSIST  = 16,
  parameter int                CNT_W    = 8,
  parameter int                STICKY   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic              proc_idle,
  input  logic              clear,
  output logic              block,
  output logic [N_AXIS-1:0] block_ch,
  output logic [1:0]        state,
  output logic [7:0]        event_cnt
);

  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_SUSPECT  = 2'b01;
  localparam logic [1:0] S_DEADLOCK = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (PERSIST < 1 || PERSIST > (2 ** CNT_W) - 1) begin : g_bad_persist
      $error("hls_deadlock_chan_monitor: PERSIST out of range for CNT_W");
    end
  endgenerate

  logic [N_AXIS-1:0] m;
  logic [N_AXIS-1:0] keep;
  logic [N_AXIS-1:0] snap;
  logic              q;
  logic [CNT_W-1:0]  cnt;

  // snap tracks the channels that have been blocked on every cycle of the
  // current suspicion window; keep is that set narrowed by this cycle's flags.
  always_comb begin
    m    = axis_block_sigs & SEL_MASK;
    q    = (|m) & ~proc_idle;
    keep = snap & m;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      block     <= 1'b0;
      block_ch  <= '0;
      event_cnt <= '0;
      cnt       <= '0;
      snap      <= '0;
    end else if (clear) begin
      state    <= S_IDLE;
      block    <= 1'b0;
      block_ch <= '0;
      cnt      <= '0;
      snap     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (q && PERSIST == 1) begin
            state    <= S_DEADLOCK;
            block    <= 1'b1;
            block_ch <= m;
            if (event_cnt != 8'hFF) event_cnt <= event_cnt + 8'd1;
          end else if (q) begin
            state <= S_SUSPECT;
            cnt   <= CNT_ONE;
            snap  <= m;
          end
        end
        S_SUSPECT: begin
          if (!q) begin
            state <= S_IDLE;
            cnt   <= '0;
            snap  <= '0;
          end else if (keep == '0) begin
            // A different channel set is blocked now: start counting afresh.
            cnt  <= CNT_ONE;
            snap <= m;
          end else if (cnt == CNT_LAST) begin
            state    <= S_DEADLOCK;
            block    <= 1'b1;
            block_ch <= keep;
            cnt      <= '0;
            snap     <= '0;
            if (event_cnt != 8'hFF) event_cnt <= event_cnt + 8'd1;
          end else begin
            cnt  <= cnt + CNT_ONE;
            snap <= keep;
          end
        end
        S_DEADLOCK: begin
          if (STICKY == 0 && !q) begin
            state    <= S_IDLE;
            block    <= 1'b0;
            block_ch <= '0;
          end
        end
        default: begin
          state    <= S_IDLE;
          block    <= 1'b0;
          block_ch <= '0;
          cnt      <= '0;
          snap     <= '0;
        end
      endcase
    end
  end

endmodule
